// File: rtl/cardinal_nic_fifo_if.sv
// PE load/store port plus router RI/SI and RO/SO handshakes of the Cardinal NIC.
// master = PE/router side driving requests, slave = the NIC itself.
interface cardinal_nic_fifo_if #(
  parameter int DATA_W = 64
);
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;
  logic              net_so;
  logic              net_ro;
  logic [DATA_W-1:0] net_do;
  logic              net_polarity;

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC: RX FIFO and two per-VC TX FIFOs; PE reads return on d_out one cycle later.
// Router backpressure via net_ri (RX full) and net_ro (gates injection of the polarity-selected VC).

module cardinal_nic_fifo_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_vld & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module cardinal_nic_fifo #(
  parameter int DATA_W   = 64,
  parameter int VC_LSB   = 0,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  cardinal_nic_fifo_if.slave  bus
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [DATA_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_cnt;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_pop;

  logic [DATA_W-1:0] tx0_head, tx1_head;
  logic [TX_CW-1:0]  tx0_cnt, tx1_cnt;
  logic              tx0_full, tx1_full;
  logic              tx0_empty, tx1_empty;
  logic              tx0_push, tx1_push;
  logic              tx0_pop, tx1_pop;

  logic              rd_en;
  logic              wr_en;
  logic              tx_wr;
  logic              tx_vc;
  logic              drop;
  logic              send;
  logic              sel;
  logic              drop_flag;
  logic [DATA_W-1:0] d_out_q;
  logic [DATA_W-1:0] rx_stat;
  logic [DATA_W-1:0] tx_stat;

  assign rd_en = bus.nicEn & ~bus.nicWrEn;
  assign wr_en = bus.nicEn & bus.nicWrEn;

  // RX path: router pushes whenever there is room.
  assign bus.net_ri = ~rx_full;
  assign rx_push    = bus.net_si & ~rx_full;
  assign rx_pop     = rd_en & (bus.addr == 2'b00) & ~rx_empty;

  cardinal_nic_fifo_buf #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (rx_push),
    .push_dat (bus.net_di),
    .pop_vld  (rx_pop),
    .head_dat (rx_head),
    .count    (rx_cnt),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  // TX path: the full check uses pre-edge occupancy, so a full queue rejects
  // a write even when it is sending on the same edge.
  assign tx_wr    = wr_en & (bus.addr == 2'b10);
  assign tx_vc    = bus.d_in[VC_LSB];
  assign tx0_push = tx_wr & ~tx_vc & ~tx0_full;
  assign tx1_push = tx_wr &  tx_vc & ~tx1_full;
  assign drop     = tx_wr & (tx_vc ? tx1_full : tx0_full);

  assign sel     = bus.net_polarity;
  assign send    = bus.net_ro & (sel ? ~tx1_empty : ~tx0_empty);
  assign tx0_pop = send & ~sel;
  assign tx1_pop = send &  sel;

  assign bus.net_so = send;
  assign bus.net_do = send ? (sel ? tx1_head : tx0_head) : '0;

  cardinal_nic_fifo_buf #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (tx0_push),
    .push_dat (bus.d_in),
    .pop_vld  (tx0_pop),
    .head_dat (tx0_head),
    .count    (tx0_cnt),
    .full     (tx0_full),
    .empty    (tx0_empty)
  );

  cardinal_nic_fifo_buf #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (tx1_push),
    .push_dat (bus.d_in),
    .pop_vld  (tx1_pop),
    .head_dat (tx1_head),
    .count    (tx1_cnt),
    .full     (tx1_full),
    .empty    (tx1_empty)
  );

  always_comb begin
    rx_stat              = '0;
    rx_stat[DATA_W-1]    = ~rx_empty;
    rx_stat[7:0]         = 8'(rx_cnt);
    tx_stat              = '0;
    tx_stat[DATA_W-1]    = tx0_full | tx1_full;
    tx_stat[DATA_W-2]    = drop_flag;
    tx_stat[15:8]        = 8'(tx1_cnt);
    tx_stat[7:0]         = 8'(tx0_cnt);
  end

  // A drop wins over the clear-on-read of the TX status word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               drop_flag <= 1'b0;
    else if (drop)                              drop_flag <= 1'b1;
    else if (rd_en && (bus.addr == 2'b11))      drop_flag <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out_q <= '0;
    end else if (rd_en) begin
      case (bus.addr)
        2'b00:   d_out_q <= rx_empty ? '0 : rx_head;
        2'b01:   d_out_q <= rx_stat;
        2'b10:   d_out_q <= '0;
        default: d_out_q <= tx_stat;
      endcase
    end else begin
      d_out_q <= '0;
    end
  end

  assign bus.d_out = d_out_q;
endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Scenario bench for cardinal_nic_fifo: queue-based models of RX and both TX VCs.
module tb_cardinal_nic_fifo;
  localparam int DW  = 64;
  localparam int RXD = 4;
  localparam int TXD = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cardinal_nic_fifo_if #(.DATA_W(DW)) bus ();

  cardinal_nic_fifo #(.DATA_W(DW), .VC_LSB(0), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx0_q[$];
  logic [DW-1:0] tx1_q[$];
  bit drop_m = 1'b0;

  function automatic logic [DW-1:0] rx_stat(input int n);
    logic [DW-1:0] s;
    s = '0;
    s[63] = (n != 0);
    s[7:0] = 8'(n);
    return s;
  endfunction

  function automatic logic [DW-1:0] tx_stat(input int n0, input int n1, input bit drp);
    logic [DW-1:0] s;
    s = '0;
    s[63] = (n0 == TXD) || (n1 == TXD);
    s[62] = drp;
    s[15:8] = 8'(n1);
    s[7:0] = 8'(n0);
    return s;
  endfunction

  function automatic void model_tx_write(input logic [DW-1:0] w);
    if (w[0]) begin
      if (tx1_q.size() < TXD) tx1_q.push_back(w); else drop_m = 1'b1;
    end else begin
      if (tx0_q.size() < TXD) tx0_q.push_back(w); else drop_m = 1'b1;
    end
  endfunction

  task automatic idle();
    bus.addr = 2'b00; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
    bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pe_read(input logic [1:0] a, output logic [DW-1:0] d);
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
    step();
    d = bus.d_out;
    bus.nicEn = 1'b0;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] w);
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = w;
    step();
    bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    step();
    tests++;
    if (bus.net_ri !== 1'b1 || bus.net_so !== 1'b0 || bus.d_out !== '0) begin
      fails++; $display("FAIL reset_init: ri=%b so=%b d_out=%h, expected ri=1 so=0 d_out=0", bus.net_ri, bus.net_so, bus.d_out);
    end
    model_tx_write(64'h54);
    pe_write(2'b10, 64'h54);
    bus.net_si = 1'b1; bus.net_di = 64'h99;
    step();
    bus.net_si = 1'b0;
    pe_read(2'b01, d);
    tests++;
    if (d !== rx_stat(1)) begin fails++; $display("FAIL reset_pre_rxstat: got %h expected %h", d, rx_stat(1)); end
    bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
    #1;
    tests++;
    if (bus.net_so !== 1'b1 || bus.net_do !== 64'h54) begin
      fails++; $display("FAIL reset_pre_send: so=%b do=%h, expected so=1 do=54", bus.net_so, bus.net_do);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (bus.net_ri !== 1'b1 || bus.net_so !== 1'b0 || bus.net_do !== '0 || bus.d_out !== '0) begin
      fails++; $display("FAIL reset_async: ri=%b so=%b do=%h d_out=%h, expected 1 0 0 0", bus.net_ri, bus.net_so, bus.net_do, bus.d_out);
    end
    #1 reset_n = 1'b1;
    bus.net_ro = 1'b0;
    rx_q.delete(); tx0_q.delete(); tx1_q.delete(); drop_m = 1'b0;
    pe_read(2'b11, d);
    tests++;
    if (d !== '0) begin fails++; $display("FAIL reset_txstat: got %h expected 0", d); end
    pe_read(2'b01, d);
    tests++;
    if (d !== '0) begin fails++; $display("FAIL reset_rxstat: got %h expected 0", d); end
  endtask

  task automatic test_rx_fill();
    logic [DW-1:0] d, e;
    int k = 0;
    bit ri;
    bus.net_si = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.net_di = 64'hA0 + k;
      ri = bus.net_ri;
      step();
      if (ri) begin rx_q.push_back(64'hA0 + k); k++; end
    end
    bus.net_si = 1'b0;
    tests++;
    if (k != RXD) begin fails++; $display("FAIL rx_accept_count: got %0d expected %0d", k, RXD); end
    tests++;
    if (bus.net_ri !== 1'b0) begin fails++; $display("FAIL rx_full_ri: got %b expected 0", bus.net_ri); end
    for (int i = 0; i < RXD; i++) begin
      pe_read(2'b01, d);
      e = rx_stat(rx_q.size());
      tests++;
      if (d !== e) begin fails++; $display("FAIL rx_status_%0d: got %h expected %h", i, d, e); end
      pe_read(2'b00, d);
      e = (rx_q.size() != 0) ? rx_q.pop_front() : '0;
      tests++;
      if (d !== e) begin fails++; $display("FAIL rx_data_%0d: got %h expected %h", i, d, e); end
    end
    pe_read(2'b01, d);
    tests++;
    if (d !== rx_stat(rx_q.size())) begin fails++; $display("FAIL rx_status_final: got %h expected %h", d, rx_stat(rx_q.size())); end
    tests++;
    if (bus.net_ri !== 1'b1) begin fails++; $display("FAIL rx_drained_ri: got %b expected 1", bus.net_ri); end
  endtask

  task automatic test_polarity();
    logic [DW-1:0] e;
    bus.net_ro = 1'b0; bus.net_polarity = 1'b1;
    model_tx_write(64'h10); pe_write(2'b10, 64'h10);
    model_tx_write(64'h11); pe_write(2'b10, 64'h11);
    bus.net_ro = 1'b1;
    #1;
    e = tx1_q.pop_front();
    tests++;
    if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
      fails++; $display("FAIL pol_vc1_first: so=%b do=%h, expected so=1 do=%h", bus.net_so, bus.net_do, e);
    end
    step();
    tests++;
    if (bus.net_so !== 1'b0) begin fails++; $display("FAIL pol_vc0_waits: so=%b expected 0", bus.net_so); end
    bus.net_polarity = 1'b0;
    #1;
    e = tx0_q.pop_front();
    tests++;
    if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
      fails++; $display("FAIL pol_vc0_sent: so=%b do=%h, expected so=1 do=%h", bus.net_so, bus.net_do, e);
    end
    step();
    tests++;
    if (bus.net_so !== 1'b0 || bus.net_do !== '0) begin
      fails++; $display("FAIL pol_idle: so=%b do=%h expected 0 0", bus.net_so, bus.net_do);
    end
    bus.net_ro = 1'b0;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d, e, w;
    bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    for (int i = 0; i <= TXD; i++) begin
      w = 64'h30 + 2 * i;
      model_tx_write(w);
      pe_write(2'b10, w);
    end
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m); drop_m = 1'b0;
    tests++;
    if (d !== e) begin fails++; $display("FAIL ovf_status: got %h expected %h", d, e); end
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m);
    tests++;
    if (d !== e) begin fails++; $display("FAIL ovf_flag_cleared: got %h expected %h", d, e); end
    // write into a full queue on the same edge it sends
    bus.net_ro = 1'b1;
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = 2'b10; bus.d_in = 64'h3A;
    #1;
    model_tx_write(64'h3A);
    e = tx0_q.pop_front();
    tests++;
    if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
      fails++; $display("FAIL ovf_send_full: so=%b do=%h, expected so=1 do=%h", bus.net_so, bus.net_do, e);
    end
    step();
    bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.net_ro = 1'b0;
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m); drop_m = 1'b0;
    tests++;
    if (d !== e) begin fails++; $display("FAIL ovf_reject_while_send: got %h expected %h", d, e); end
    bus.net_ro = 1'b1;
    #1;
    for (int i = 0; i < 2 * TXD && tx0_q.size() != 0; i++) begin
      e = tx0_q.pop_front();
      tests++;
      if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
        fails++; $display("FAIL ovf_drain_%0d: so=%b do=%h, expected so=1 do=%h", i, bus.net_so, bus.net_do, e);
      end
      step();
      #1;
    end
    tests++;
    if (bus.net_so !== 1'b0) begin fails++; $display("FAIL ovf_drained: so=%b expected 0", bus.net_so); end
    bus.net_ro = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d, e, es;
    bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    model_tx_write(64'h20); pe_write(2'b10, 64'h20);
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m);
    tests++;
    if (d !== e) begin fails++; $display("FAIL sim_occ_before: got %h expected %h", d, e); end
    bus.net_ro = 1'b1;
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = 2'b10; bus.d_in = 64'h22;
    #1;
    model_tx_write(64'h22);
    e = tx0_q.pop_front();
    tests++;
    if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
      fails++; $display("FAIL sim_head_send: so=%b do=%h, expected so=1 do=%h", bus.net_so, bus.net_do, e);
    end
    step();
    bus.nicWrEn = 1'b0; bus.addr = 2'b11;
    #1;
    es = tx_stat(tx0_q.size(), tx1_q.size(), drop_m);
    e = tx0_q.pop_front();
    tests++;
    if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
      fails++; $display("FAIL sim_next_send: so=%b do=%h, expected so=1 do=%h", bus.net_so, bus.net_do, e);
    end
    step();
    bus.nicEn = 1'b0; bus.net_ro = 1'b0;
    tests++;
    if (bus.d_out !== es) begin fails++; $display("FAIL sim_occ_during: got %h expected %h", bus.d_out, es); end
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m);
    tests++;
    if (d !== e) begin fails++; $display("FAIL sim_occ_after: got %h expected %h", d, e); end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] d, e;
    bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    model_tx_write(64'h40); pe_write(2'b10, 64'h40);
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m);
    tests++;
    if (d !== e) begin fails++; $display("FAIL ill_txstat_pre: got %h expected %h", d, e); end
    pe_read(2'b00, d);
    tests++;
    if (d !== '0) begin fails++; $display("FAIL ill_empty_read: got %h expected 0", d); end
    pe_read(2'b01, d);
    tests++;
    if (d !== rx_stat(rx_q.size())) begin fails++; $display("FAIL ill_empty_unchanged: got %h expected %h", d, rx_stat(rx_q.size())); end
    bus.net_si = 1'b1; bus.net_di = 64'h77;
    step();
    bus.net_si = 1'b0;
    rx_q.push_back(64'h77);
    pe_read(2'b01, d);
    pe_write(2'b01, 64'h41);
    tests++;
    if (bus.d_out !== '0) begin fails++; $display("FAIL ill_dout_on_write: got %h expected 0", bus.d_out); end
    pe_write(2'b00, 64'h43);
    pe_write(2'b11, 64'h45);
    pe_read(2'b10, d);
    tests++;
    if (d !== '0) begin fails++; $display("FAIL ill_read10: got %h expected 0", d); end
    pe_read(2'b11, d);
    e = tx_stat(tx0_q.size(), tx1_q.size(), drop_m);
    tests++;
    if (d !== e) begin fails++; $display("FAIL ill_txstat_post: got %h expected %h", d, e); end
    pe_read(2'b01, d);
    e = rx_stat(rx_q.size());
    tests++;
    if (d !== e) begin fails++; $display("FAIL ill_rxstat_post: got %h expected %h", d, e); end
    pe_read(2'b00, d);
    e = rx_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL ill_rx_data: got %h expected %h", d, e); end
    bus.net_ro = 1'b1;
    #1;
    for (int i = 0; i < 2 * TXD && tx0_q.size() != 0; i++) begin
      e = tx0_q.pop_front();
      tests++;
      if (bus.net_so !== 1'b1 || bus.net_do !== e) begin
        fails++; $display("FAIL ill_drain_%0d: so=%b do=%h, expected so=1 do=%h", i, bus.net_so, bus.net_do, e);
      end
      step();
      #1;
    end
    tests++;
    if (bus.net_so !== 1'b0) begin fails++; $display("FAIL ill_drained: so=%b expected 0", bus.net_so); end
    bus.net_ro = 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    test_reset();
    test_rx_fill();
    test_polarity();
    test_overflow();
    test_simultaneous();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cardinal_nic_fifo.md
# cardinal_nic_fifo

Parametrised network interface controller between a processing element (PE) and its local Cardinal router port. It replaces the single-word RX/TX buffers with a configurable-depth RX FIFO and two per-virtual-channel TX FIFOs, so a flit waiting for the other polarity does not block one that is ready now. The PE sees the same 2-bit load/store address map, with richer status words. The router side uses the RI/SI and RO/SO handshakes with polarity-gated injection.

## Interface
- DATA_W, 64, flit and PE data width
- VC_LSB, 0, bit of a flit that carries its VC/polarity
- RX_DEPTH, 4, RX FIFO depth; power of two, 2..128
- TX_DEPTH, 4, depth of each TX FIFO (VC0 and VC1); power of two, 2..128

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- addr  in  2  PE location select: 00 RX data, 01 RX status, 10 TX data, 11 TX status
- d_in  in  DATA_W  PE write data
- d_out  out  DATA_W  PE read data (registered)
- nicEn  in  1  NIC selected
- nicWrEn  in  1  1 = write, 0 = read
- net_si  in  1  router sending a flit to the NIC
- net_ri  out  1  NIC can accept a flit
- net_di  in  DATA_W  flit from the router
- net_so  out  1  NIC sending a flit to the router
- net_ro  in  1  router can accept a flit
- net_do  out  DATA_W  flit to the router
- net_polarity  in  1  VC currently allowed on the external link

## Operation
- Reset (asserted asynchronously while reset_n=0):
  - All FIFOs are empty; the drop flag is cleared; d_out=0.
  - As a result, net_ri=1, net_so=0 and net_do=0.
- RX path:
  - net_ri = !rx_full, combinational.
  - A flit is pushed on each edge where net_si & net_ri.
- RX data read (nicEn & !nicWrEn & addr=00):
  - If the RX FIFO is non-empty: d_out <= head, and the head is popped on the same edge.
  - If the RX FIFO is empty: d_out <= 0, and nothing is popped.
- RX status read (addr=01):
  - d_out[63] = rx non-empty.
  - d_out[7:0] = rx occupancy.
  - All other bits are 0.
- TX data write (nicEn & nicWrEn & addr=10):
  - The write targets queue q = d_in[VC_LSB].
  - If queue q is not full, d_in is pushed into q.
  - If queue q is full, the word is dropped and drop_flag is set.
  - A full queue rejects the write even if it sends a flit on the same edge.
- Writes to addr 00, 01 or 11 are ignored with no state change.
- Reads of addr 10 return 0.
- TX status read (addr=11):
  - d_out[63] = VC0 full | VC1 full.
  - d_out[62] = drop_flag.
  - d_out[15:8] = VC1 occupancy.
  - d_out[7:0] = VC0 occupancy.
  - All other bits are 0.
  - This read clears drop_flag on the same edge. A drop on that same edge takes priority, so the flag stays set.
- Injection:
  - sel = net_polarity.
  - send = queue[sel] non-empty & net_ro.
  - net_so = send, combinational.
  - net_do = head of queue[sel] when send, else 0.
  - queue[sel] is popped on each edge where send is true.
  - The other queue is never presented to the router.
- A PE push and a send to the same non-full queue may happen on the same edge. Occupancy is then unchanged and FIFO order is preserved.
- d_out <= 0 on every edge that is not a read, including writes and nicEn=0.
- Occupancy counters are $clog2(depth)+1 bits wide, zero-extended into the status fields. Pointers wrap modulo depth.

## Timing
- PE read latency: 1 cycle. Data and status appear in d_out after the edge that samples the request.
- RX visibility: a flit accepted on edge k is readable by a read sampled on edge k+1. The status at that read already counts it.
- TX visibility: a word written on edge k can drive net_so in the cycle after edge k, if polarity matches and net_ro=1.
- net_ri and net_so/net_do are combinational from state and inputs, with no extra register stage.
- When reset_n rises again, the first operation is accepted on the next rising edge.
- Reset asserted mid-traffic discards all queued flits immediately. net_so falls without waiting for a clock edge.

## Test plan
- Reset values: pulse reset_n low between clock edges -> all outputs take their reset values asynchronously: net_ri=1, net_so=0, d_out=0. A read of 11 then returns 0.
- RX fill: RX_DEPTH=4. Drive net_si with flits 0xA0..0xA4 continuously -> net_ri falls after the 4th acceptance, and the 5th flit is held. Four reads of 00 return 0xA0..0xA3 in order. The 01 status shows 4, 3, 2, 1, 0 along the way.
- Polarity gating:
  - Write 0x10 (VC0) then 0x11 (VC1) with net_polarity=1 and net_ro=1 -> 0x11 is sent first; 0x10 waits.
  - Then set polarity to 0 -> 0x10 is sent.
- Overflow:
  - Write TX_DEPTH+1 VC0 words with net_ro=0 -> the last word is dropped. The 11 status reads bit63=1, bit62=1, [7:0]=4.
  - A second 11 read shows bit62=0.
- Simultaneous traffic on a non-full queue:
  - One VC0 word is already queued; net_ro=1; polarity 0.
  - On one edge, the PE writes VC0 word 0x22 while the head is sent -> the next cycle sends 0x22, and the occupancy profile is 1, 1, 0.
- Empty read and illegal ops: read 00 when empty -> d_out=0 and the RX state is unchanged. A write to 01 and a read of 10 leave all occupancies unchanged.
